sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
- Initiator side of the board SRAM interface; the bus master driving the base and ext 32-bit asynchronous SRAM chips.
- Accepts one word-aligned CPU/MMU memory request at a time and steps through chip-enable, output-enable and write-enable phases with configurable wait cycles.
- Performs read-modify-write for partial byte writes, because the chips have no byte enables.
- Sits between the memory-stage bus arbiter and the top-level SRAM pins.

Parameters:
- ADDR_W, 20, SRAM word-address width per chip (matches `RAMAddrBus).
- RD_WAIT, 1, cycles CE/OE held low before read data is sampled (≥1).
- WR_WAIT, 1, cycles WE held low with data driven (≥1).
- CHIP_SEL_BIT, 22, byte-address bit selecting ext (1) or base (0).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- mem_ce_i  in  1  request valid; held stable until mem_ack_o.
- mem_we_i  in  1  1=write, 0=read.
- mem_addr_i  in  32  byte address; bits[1:0] ignored; SRAM word address = mem_addr_i[ADDR_W+1:2].
- mem_sel_i  in  4  byte enables; sel[0]→data[7:0] … sel[3]→data[31:24].
- mem_data_i  in  32  write data.
- mem_data_o  out  32  read data; valid while mem_ack_o=1.
- mem_ack_o  out  1  one-cycle completion pulse.
- base_ram_addr  out  ADDR_W  base chip word address.
- base_ram_ce / base_ram_oe / base_ram_we  out  1 each  active-low strobes.
- base_ram_data  inout  32  base data bus.
- ext_ram_addr  out  ADDR_W  ext chip word address.
- ext_ram_ce / ext_ram_oe / ext_ram_we  out  1 each  active-low strobes.
- ext_ram_data  inout  32  ext data bus.

Behaviour:
- All pin and handshake outputs are registered.
- Reset values: all ce/oe/we=1; addr=0; both data buses high-Z; mem_ack_o=0; mem_data_o=0; state=IDLE.
- States:
  - IDLE: on mem_ce_i=1, latch addr/we/sel/data and select the chip by addr[CHIP_SEL_BIT].
    - Read, or write with sel≠4'b1111 and sel≠0 → RD.
    - Write with sel=4'b1111 → WR.
    - Write with sel=0 → ACK (no SRAM access).
  - RD: selected chip ce=0, oe=0, we=1; hold RD_WAIT cycles. On the last cycle, capture the chip's data bus.
    - Read → ACK, with mem_data_o = captured word.
    - Partial write → merge: per byte, sel?mem_data_i byte:captured byte → WR.
  - WR: selected chip ce=0, oe=1, we=0; drive the merged or full data on the selected chip's bus for WR_WAIT cycles → ACK.
  - ACK: all strobes inactive; mem_ack_o=1 for exactly this cycle → IDLE. No new request is accepted in ACK.
- Unselected chip: ce=oe=we=1, bus high-Z at all times.
- A chip's bus is driven only while that chip's we=0. Oe and we are never both 0.
- RD→WR transition: oe returns to 1 in the same edge that we goes to 0; no overlap cycle, and the bus is released in RD.
- Latency, counting request-accept edge → ack cycle:
  - read: RD_WAIT+1 cycles
  - full write: WR_WAIT+1 cycles
  - partial write: RD_WAIT+WR_WAIT+1 cycles
- Throughput: at most one request per latency+1 cycles.
- Request fields are sampled only in IDLE; changes while busy are ignored.
- rst asserted in any state: at the next edge all outputs return to reset values and state goes to IDLE. An aborted write may leave the SRAM word undefined; no ack is issued.

Decomposition:
- defines.v additions:
  - state encodings (IDLE/RD/WR/ACK)
  - `RAMAddrBus, `RAMBus
  - CHIP_SEL_BIT default
  - strobe active/inactive constants
- One natural sub-module: sram_byte_merge (combinational; captured word + write data + sel → merged word), reused by a future cache write path.
- Tristate drivers stay in sram_ctrl.

Test Plan:
- Full write then read: write addr 0x0000_0010, sel 1111, data 0xDEADBEEF, then read the same address.
  - ack after 2 cycles each; base word 4 = 0xDEADBEEF; read returns 0xDEADBEEF; ext strobes stay 1.
- Chip select: write 0x0040_0008 (bit 22 set), data 0x12345678.
  - Only ext_ram_we pulses low; ext word 2 written; base bus stays high-Z throughout.
- Partial write: preload word 0x11223344, then write sel 0101 with data 0xAABBCCDD.
  - RD phase then WR phase; stored word 0x11BB33DD; ack at cycle 3.
- sel=0 write: request asserted with sel 0000.
  - ack on the next cycle; no ce/oe/we activity; memory unchanged.
- Bus discipline: throughout a randomized mixed sequence, assert oe&we never both 0, each bus driven only when its we=0, and ack is always a single-cycle pulse.
- Reset mid-op: assert rst during the RD phase of a partial write.
  - Next edge: all strobes 1, buses high-Z, no ack.
  - A following read at 0x10 completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the board SRAM controller and its helpers.
// Imported by the interface, the byte-merge helper and the controller top.
package sram_ctrl_pkg;

  localparam int RAM_BUS_W        = 32;
  localparam int RAM_ADDR_W_DEF   = 20;
  localparam int CHIP_SEL_BIT_DEF = 22;

  // SRAM strobes are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam logic [3:0] SEL_FULL = 4'b1111;
  localparam logic [3:0] SEL_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  // A partial write needs a read of the old word before it can be stored.
  function automatic logic is_partial(input logic [3:0] sel);
    return (sel != SEL_FULL) && (sel != SEL_NONE);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Memory-stage request/ack bus between the arbiter (master) and the SRAM
// controller (slave). One word-aligned request at a time.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic                 mem_ce_i;
  logic                 mem_we_i;
  logic [31:0]          mem_addr_i;
  logic [3:0]           mem_sel_i;
  logic [RAM_BUS_W-1:0] mem_data_i;
  logic [RAM_BUS_W-1:0] mem_data_o;
  logic                 mem_ack_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o
  );
endinterface

// File: rtl/sram_byte_merge.sv
// Combinational byte merge: bytes with sel set come from the write word,
// the rest keep the previously stored word.
module sram_byte_merge
  import sram_ctrl_pkg::*;
(
  input  logic [RAM_BUS_W-1:0] rd_word,
  input  logic [RAM_BUS_W-1:0] wr_word,
  input  logic [3:0]           sel,
  output logic [RAM_BUS_W-1:0] merged
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign merged[gi*8 +: 8] = sel[gi] ? wr_word[gi*8 +: 8] : rd_word[gi*8 +: 8];
  end

endmodule

// File: rtl/sram_ctrl.sv
// Initiator for the base/ext asynchronous SRAM chips: sequences CE/OE/WE with
// configurable wait cycles and does read-modify-write for partial byte writes.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W       = RAM_ADDR_W_DEF,
  parameter int RD_WAIT      = 1,
  parameter int WR_WAIT      = 1,
  parameter int CHIP_SEL_BIT = CHIP_SEL_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_ctrl_if.slave           mem,
  output logic [ADDR_W-1:0]    base_ram_addr,
  output logic                 base_ram_ce,
  output logic                 base_ram_oe,
  output logic                 base_ram_we,
  inout  wire  [RAM_BUS_W-1:0] base_ram_data,
  output logic [ADDR_W-1:0]    ext_ram_addr,
  output logic                 ext_ram_ce,
  output logic                 ext_ram_oe,
  output logic                 ext_ram_we,
  inout  wire  [RAM_BUS_W-1:0] ext_ram_data
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 chip_reg, chip_next;   // 1 = ext chip
  logic                 we_req_reg, we_req_next;
  logic [3:0]           sel_reg, sel_next;
  logic [RAM_BUS_W-1:0] wdata_reg, wdata_next;
  logic [RAM_BUS_W-1:0] rdata_reg, rdata_next;
  logic [ADDR_W-1:0]    base_addr_reg, base_addr_next;
  logic [ADDR_W-1:0]    ext_addr_reg, ext_addr_next;
  logic                 base_ce_reg, base_ce_next;
  logic                 base_oe_reg, base_oe_next;
  logic                 base_we_reg, base_we_next;
  logic                 ext_ce_reg, ext_ce_next;
  logic                 ext_oe_reg, ext_oe_next;
  logic                 ext_we_reg, ext_we_next;
  logic                 ack_reg, ack_next;

  logic [RAM_BUS_W-1:0] rd_bus;
  logic [RAM_BUS_W-1:0] merged_word;
  logic                 access_next;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^mem.mem_addr_i;
  assign rd_bus = chip_reg ? ext_ram_data : base_ram_data;

  sram_byte_merge u_merge (
    .rd_word (rd_bus),
    .wr_word (wdata_reg),
    .sel     (sel_reg),
    .merged  (merged_word)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    chip_next      = chip_reg;
    we_req_next    = we_req_reg;
    sel_next       = sel_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    base_addr_next = base_addr_reg;
    ext_addr_next  = ext_addr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (mem.mem_ce_i) begin
          chip_next   = mem.mem_addr_i[CHIP_SEL_BIT];
          we_req_next = mem.mem_we_i;
          sel_next    = mem.mem_sel_i;
          wdata_next  = mem.mem_data_i;
          if (mem.mem_addr_i[CHIP_SEL_BIT]) begin
            ext_addr_next = mem.mem_addr_i[ADDR_W+1:2];
          end else begin
            base_addr_next = mem.mem_addr_i[ADDR_W+1:2];
          end
          if (!mem.mem_we_i || is_partial(mem.mem_sel_i)) begin
            state_next = ST_RD;
            cnt_next   = RD_LOAD;
          end else if (mem.mem_sel_i == SEL_FULL) begin
            state_next = ST_WR;
            cnt_next   = WR_LOAD;
          end else begin
            state_next = ST_ACK;
          end
        end
      end
      ST_RD: begin
        if (cnt_reg == '0) begin
          // Bus is sampled on this edge; OE releases as WE asserts.
          if (we_req_reg) begin
            wdata_next = merged_word;
            state_next = ST_WR;
            cnt_next   = WR_LOAD;
          end else begin
            rdata_next = rd_bus;
            state_next = ST_ACK;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_WR: begin
        if (cnt_reg == '0) begin
          state_next = ST_ACK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Strobes are derived from the next state so the pins come straight off flops.
    access_next  = (state_next == ST_RD) || (state_next == ST_WR);
    base_ce_next = (access_next && !chip_next) ? STROBE_ON : STROBE_OFF;
    base_oe_next = ((state_next == ST_RD) && !chip_next) ? STROBE_ON : STROBE_OFF;
    base_we_next = ((state_next == ST_WR) && !chip_next) ? STROBE_ON : STROBE_OFF;
    ext_ce_next  = (access_next && chip_next) ? STROBE_ON : STROBE_OFF;
    ext_oe_next  = ((state_next == ST_RD) && chip_next) ? STROBE_ON : STROBE_OFF;
    ext_we_next  = ((state_next == ST_WR) && chip_next) ? STROBE_ON : STROBE_OFF;
    ack_next     = (state_next == ST_ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      chip_reg      <= 1'b0;
      we_req_reg    <= 1'b0;
      sel_reg       <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      base_addr_reg <= '0;
      ext_addr_reg  <= '0;
      base_ce_reg   <= STROBE_OFF;
      base_oe_reg   <= STROBE_OFF;
      base_we_reg   <= STROBE_OFF;
      ext_ce_reg    <= STROBE_OFF;
      ext_oe_reg    <= STROBE_OFF;
      ext_we_reg    <= STROBE_OFF;
      ack_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      chip_reg      <= chip_next;
      we_req_reg    <= we_req_next;
      sel_reg       <= sel_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      base_addr_reg <= base_addr_next;
      ext_addr_reg  <= ext_addr_next;
      base_ce_reg   <= base_ce_next;
      base_oe_reg   <= base_oe_next;
      base_we_reg   <= base_we_next;
      ext_ce_reg    <= ext_ce_next;
      ext_oe_reg    <= ext_oe_next;
      ext_we_reg    <= ext_we_next;
      ack_reg       <= ack_next;
    end
  end

  // Each bus is driven exactly while its own WE pin is low.
  assign base_ram_data = (base_we_reg == STROBE_ON) ? wdata_reg : {RAM_BUS_W{1'bz}};
  assign ext_ram_data  = (ext_we_reg  == STROBE_ON) ? wdata_reg : {RAM_BUS_W{1'bz}};

  assign base_ram_addr  = base_addr_reg;
  assign base_ram_ce    = base_ce_reg;
  assign base_ram_oe    = base_oe_reg;
  assign base_ram_we    = base_we_reg;
  assign ext_ram_addr   = ext_addr_reg;
  assign ext_ram_ce     = ext_ce_reg;
  assign ext_ram_oe     = ext_oe_reg;
  assign ext_ram_we     = ext_we_reg;
  assign mem.mem_ack_o  = ack_reg;
  assign mem.mem_data_o = rdata_reg;

endmodule
